// File: rtl/cmd_scheduler.sv
// -----------------------------------------------------------------------------
// cmd_scheduler
// Shares the single SD CMD control unit between two requesters (req0: host
// register interface, req1: data block auto-stop/auto-CMD). The winner is picked
// round-robin, its command is latched and presented to the control unit, a
// timeout is generated from an internal cycle counter, the strobe/ack four-phase
// handshake is closed, and the response is returned to the winner.
//
// Ports:
//   clock, reset              clock, async active-high reset
//   reqN_valid/index/argument/timeout_en   command request from requester N
//   reqN_ready                one-cycle pulse: command accepted
//   reqN_done                 one-cycle pulse: command finished, rsp_* valid
//   new_command, cmd_index, cmd_argument, timeout_enable, time_out, ack_out
//                             drive the control unit
//   ctl_strobe, ctl_response  command-phase-ended level and response from it
//   rsp_data, rsp_timeout, rsp_id   result of the last completed command
//   busy                      scheduler is not idle
// -----------------------------------------------------------------------------
module cmd_scheduler #(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int TIMEOUT_W      = 16
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          req0_valid,
   input  logic [5:0]    req0_index,
   input  logic [31:0]   req0_argument,
   input  logic          req0_timeout_en,
   output logic          req0_ready,
   output logic          req0_done,
   input  logic          req1_valid,
   input  logic [5:0]    req1_index,
   input  logic [31:0]   req1_argument,
   input  logic          req1_timeout_en,
   output logic          req1_ready,
   output logic          req1_done,
   output logic          new_command,
   output logic [5:0]    cmd_index,
   output logic [31:0]   cmd_argument,
   output logic          timeout_enable,
   output logic          time_out,
   output logic          ack_out,
   input  logic          ctl_strobe,
   input  logic [135:0]  ctl_response,
   output logic [135:0]  rsp_data,
   output logic          rsp_timeout,
   output logic          rsp_id,
   output logic          busy
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_ACK  = 2'd2
   } state_t;

   localparam logic [TIMEOUT_W-1:0] TERM_C    = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [TIMEOUT_W-1:0] CNT_MAX_C = {TIMEOUT_W{1'b1}};

   state_t                state_q, state_d;
   logic                  last_grant_q, last_grant_d;
   logic                  grantee_q, grantee_d;
   logic [TIMEOUT_W-1:0]  cnt_q, cnt_d;
   logic                  req0_ready_q, req0_ready_d;
   logic                  req1_ready_q, req1_ready_d;
   logic                  req0_done_q, req0_done_d;
   logic                  req1_done_q, req1_done_d;
   logic                  new_command_q, new_command_d;
   logic [5:0]            cmd_index_q, cmd_index_d;
   logic [31:0]           cmd_argument_q, cmd_argument_d;
   logic                  timeout_enable_q, timeout_enable_d;
   logic                  time_out_q, time_out_d;
   logic                  ack_out_q, ack_out_d;
   logic [135:0]          rsp_data_q, rsp_data_d;
   logic                  rsp_timeout_q, rsp_timeout_d;
   logic                  rsp_id_q, rsp_id_d;
   logic                  busy_q, busy_d;
   logic                  grant_sel_s;

   // State and output registers; reset aborts any command without a done pulse.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q          <= ST_IDLE;
         last_grant_q     <= 1'b1;
         grantee_q        <= 1'b0;
         cnt_q            <= '0;
         req0_ready_q     <= 1'b0;
         req1_ready_q     <= 1'b0;
         req0_done_q      <= 1'b0;
         req1_done_q      <= 1'b0;
         new_command_q    <= 1'b0;
         cmd_index_q      <= 6'd0;
         cmd_argument_q   <= 32'd0;
         timeout_enable_q <= 1'b0;
         time_out_q       <= 1'b0;
         ack_out_q        <= 1'b0;
         rsp_data_q       <= 136'd0;
         rsp_timeout_q    <= 1'b0;
         rsp_id_q         <= 1'b0;
         busy_q           <= 1'b0;
      end else begin
         state_q          <= state_d;
         last_grant_q     <= last_grant_d;
         grantee_q        <= grantee_d;
         cnt_q            <= cnt_d;
         req0_ready_q     <= req0_ready_d;
         req1_ready_q     <= req1_ready_d;
         req0_done_q      <= req0_done_d;
         req1_done_q      <= req1_done_d;
         new_command_q    <= new_command_d;
         cmd_index_q      <= cmd_index_d;
         cmd_argument_q   <= cmd_argument_d;
         timeout_enable_q <= timeout_enable_d;
         time_out_q       <= time_out_d;
         ack_out_q        <= ack_out_d;
         rsp_data_q       <= rsp_data_d;
         rsp_timeout_q    <= rsp_timeout_d;
         rsp_id_q         <= rsp_id_d;
         busy_q           <= busy_d;
      end
   end

   // Round-robin pick: on a tie the requester that did not win last time wins.
   always_comb begin
      grant_sel_s = 1'b0;
      if (req0_valid && req1_valid) begin
         grant_sel_s = ~last_grant_q;
      end else begin
         grant_sel_s = ~req0_valid;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d          = state_q;
      last_grant_d     = last_grant_q;
      grantee_d        = grantee_q;
      cnt_d            = cnt_q;
      req0_ready_d     = 1'b0;
      req1_ready_d     = 1'b0;
      req0_done_d      = 1'b0;
      req1_done_d      = 1'b0;
      new_command_d    = new_command_q;
      cmd_index_d      = cmd_index_q;
      cmd_argument_d   = cmd_argument_q;
      timeout_enable_d = timeout_enable_q;
      time_out_d       = 1'b0;
      ack_out_d        = ack_out_q;
      rsp_data_d       = rsp_data_q;
      rsp_timeout_d    = rsp_timeout_q;
      rsp_id_d         = rsp_id_q;

      case (state_q)
         ST_IDLE: begin
            if (req0_valid || req1_valid) begin
               grantee_d        = grant_sel_s;
               last_grant_d     = grant_sel_s;
               cmd_index_d      = grant_sel_s ? req1_index      : req0_index;
               cmd_argument_d   = grant_sel_s ? req1_argument   : req0_argument;
               timeout_enable_d = grant_sel_s ? req1_timeout_en : req0_timeout_en;
               req0_ready_d     = ~grant_sel_s;
               req1_ready_d     = grant_sel_s;
               new_command_d    = 1'b1;
               cnt_d            = '0;
               state_d          = ST_BUSY;
            end else begin
               new_command_d    = 1'b0;
            end
         end
         ST_BUSY: begin
            // Saturate so a timeout-disabled command never wraps into a false count.
            cnt_d = (cnt_q == CNT_MAX_C) ? cnt_q : cnt_q + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
            if (ctl_strobe) begin
               // Strobe takes priority over a coincident terminal count.
               rsp_data_d    = ctl_response;
               rsp_timeout_d = 1'b0;
               rsp_id_d      = grantee_q;
               new_command_d = 1'b0;
               ack_out_d     = 1'b1;
               state_d       = ST_ACK;
            end else if (timeout_enable_q && (cnt_q == TERM_C)) begin
               time_out_d    = 1'b1;
               rsp_timeout_d = 1'b1;
               rsp_id_d      = grantee_q;
               new_command_d = 1'b0;
               ack_out_d     = 1'b1;
               state_d       = ST_ACK;
            end else begin
               new_command_d = 1'b1;
            end
         end
         ST_ACK: begin
            if (!ctl_strobe) begin
               ack_out_d   = 1'b0;
               req0_done_d = ~grantee_q;
               req1_done_d = grantee_q;
               state_d     = ST_IDLE;
            end else begin
               ack_out_d   = 1'b1;
            end
         end
         default: begin
            new_command_d = 1'b0;
            ack_out_d     = 1'b0;
            state_d       = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   assign req0_ready     = req0_ready_q;
   assign req1_ready     = req1_ready_q;
   assign req0_done      = req0_done_q;
   assign req1_done      = req1_done_q;
   assign new_command    = new_command_q;
   assign cmd_index      = cmd_index_q;
   assign cmd_argument   = cmd_argument_q;
   assign timeout_enable = timeout_enable_q;
   assign time_out       = time_out_q;
   assign ack_out        = ack_out_q;
   assign rsp_data       = rsp_data_q;
   assign rsp_timeout    = rsp_timeout_q;
   assign rsp_id         = rsp_id_q;
   assign busy           = busy_q;

endmodule

// File: tb/tb_cmd_scheduler.sv
// -----------------------------------------------------------------------------
// tb_cmd_scheduler
// Self-checking bench for cmd_scheduler. Expected completions are pushed to a
// scoreboard when each command is driven and popped when a done pulse appears.
// -----------------------------------------------------------------------------
module tb_cmd_scheduler;

   localparam int TO_C = 8;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          req0_valid = 1'b0;
   logic [5:0]    req0_index = 6'd0;
   logic [31:0]   req0_argument = 32'd0;
   logic          req0_timeout_en = 1'b0;
   logic          req0_ready, req0_done;
   logic          req1_valid = 1'b0;
   logic [5:0]    req1_index = 6'd0;
   logic [31:0]   req1_argument = 32'd0;
   logic          req1_timeout_en = 1'b0;
   logic          req1_ready, req1_done;
   logic          new_command, timeout_enable, time_out, ack_out;
   logic [5:0]    cmd_index;
   logic [31:0]   cmd_argument;
   logic          ctl_strobe = 1'b0;
   logic [135:0]  ctl_response = 136'd0;
   logic [135:0]  rsp_data;
   logic          rsp_timeout, rsp_id, busy;

   cmd_scheduler #(.TIMEOUT_CYCLES(TO_C), .TIMEOUT_W(16)) dut (
      .clock(clock), .reset(reset),
      .req0_valid(req0_valid), .req0_index(req0_index), .req0_argument(req0_argument),
      .req0_timeout_en(req0_timeout_en), .req0_ready(req0_ready), .req0_done(req0_done),
      .req1_valid(req1_valid), .req1_index(req1_index), .req1_argument(req1_argument),
      .req1_timeout_en(req1_timeout_en), .req1_ready(req1_ready), .req1_done(req1_done),
      .new_command(new_command), .cmd_index(cmd_index), .cmd_argument(cmd_argument),
      .timeout_enable(timeout_enable), .time_out(time_out), .ack_out(ack_out),
      .ctl_strobe(ctl_strobe), .ctl_response(ctl_response),
      .rsp_data(rsp_data), .rsp_timeout(rsp_timeout), .rsp_id(rsp_id), .busy(busy)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic          id;
      logic          to;
      logic [135:0]  data;
   } exp_t;

   exp_t          sb_q[$];
   logic [135:0]  model_rsp = 136'd0;
   int            n_checks = 0;
   int            n_errors = 0;

   task automatic check_eq(input string tag, input logic [135:0] obs, input logic [135:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Scoreboard side: every done pulse must match the oldest expected completion.
   always @(negedge clock) begin
      if (!reset && (req0_ready || req1_ready)) begin
         check_eq("ready_excl", {1'b0, req0_ready & req1_ready}, 2'd0);
      end
      if (!reset && (req0_done || req1_done)) begin
         if (sb_q.size() == 0) begin
            check_eq("unexpected_done", {req1_done, req0_done}, 2'd0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check_eq("done_id", {req1_done, req0_done}, e.id ? 2'b10 : 2'b01);
            check_eq("rsp_id", rsp_id, e.id);
            check_eq("rsp_timeout", rsp_timeout, e.to);
            check_eq("rsp_data", rsp_data, e.data);
         end
      end
   end

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_outs"},
               {req0_ready, req0_done, req1_ready, req1_done, new_command, timeout_enable,
                time_out, ack_out, rsp_timeout, rsp_id, busy}, 11'd0);
      check_eq({tag, "_cmd"}, {cmd_index, cmd_argument}, 38'd0);
      check_eq({tag, "_rsp_data"}, rsp_data, 136'd0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      sb_q.delete();
      model_rsp = 136'd0;
      tick();
      tick();
      check_all_zero("reset");
      reset = 1'b0;
   endtask

   task automatic wait_grant(input logic id);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (!(req0_ready || req1_ready) && n < 20);
      if (!(req0_ready || req1_ready)) begin
         check_eq("grant_timeout", 1'b0, 1'b1);
      end else begin
         check_eq("grant_id", {req1_ready, req0_ready}, id ? 2'b10 : 2'b01);
         check_eq("grant_nc", {new_command, busy}, 2'b11);
      end
   endtask

   // Runs BUSY/ACK; n_strobe = edge (after grant) at which strobe is sampled, 0 = never.
   task automatic drive_phase(input int n_strobe, input logic [135:0] resp, input logic exp_to,
                              input logic id);
      int nc, n;
      logic to_seen;
      nc = 1;
      n = 0;
      to_seen = 1'b0;
      while (new_command && n < 300) begin
         n++;
         if (n == n_strobe) begin
            ctl_strobe = 1'b1;
            ctl_response = resp;
         end
         tick();
         if (time_out) to_seen = 1'b1;
         if (new_command) nc++;
      end
      check_eq("nc_len", nc, exp_to ? TO_C : n_strobe);
      check_eq("time_out", to_seen, exp_to);
      check_eq("ack_hi", ack_out, 1'b1);
      if (!exp_to) begin
         repeat (2) begin
            tick();
            check_eq("ack_hold", {ack_out, req0_done | req1_done}, 2'b10);
         end
         ctl_strobe = 1'b0;
      end
      tick();
      if (exp_to) check_eq("to_pulse_len", time_out, 1'b0);
      check_eq("done_seen", id ? req1_done : req0_done, 1'b1);
      check_eq("post_done", {ack_out, new_command, busy}, 3'b000);
   endtask

   task automatic do_cmd(input logic id, input logic [5:0] idx, input logic [31:0] arg,
                         input logic ten, input int n_strobe, input logic [135:0] resp);
      logic exp_to;
      exp_t e;
      exp_to = ten && (n_strobe == 0 || n_strobe > TO_C);
      e.id = id;
      e.to = exp_to;
      e.data = exp_to ? model_rsp : resp;
      sb_q.push_back(e);
      if (!exp_to) model_rsp = resp;
      if (id) begin
         req1_valid = 1'b1; req1_index = idx; req1_argument = arg; req1_timeout_en = ten;
      end else begin
         req0_valid = 1'b1; req0_index = idx; req0_argument = arg; req0_timeout_en = ten;
      end
      wait_grant(id);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      check_eq("cmd_latch", {cmd_index, cmd_argument, timeout_enable}, {idx, arg, ten});
      drive_phase(n_strobe, resp, exp_to, id);
   endtask

   initial begin
      logic [135:0] r;
      #2;
      check_all_zero("por");
      do_reset();

      // Normal req0 command, strobe after 5 cycles.
      do_cmd(1'b0, 6'b011000, 32'hFF99FF88, 1'b1, 5, 136'h00FFFF9999EEEE8888DDDD7777CCCC6666);
      // req1 timeout, no strobe; rsp_data must keep the previous response.
      do_cmd(1'b1, 6'd12, 32'h1234_5678, 1'b1, 0, 136'd0);
      // Timeout disabled, strobe after 200 cycles.
      do_cmd(1'b0, 6'd17, 32'hCAFE_0001, 1'b0, 200, 136'hA5A5_0000_1111_2222_3333_4444_5555_6666_77);
      // Strobe coincides with the terminal count: strobe wins.
      do_cmd(1'b1, 6'd41, 32'h0BAD_F00D, 1'b1, TO_C, 136'h5A_0F0F_F0F0_1234_ABCD_9876_0000_FFFF_0001);

      // Both requesters held: expect grants 0,1,0,1.
      do_reset();
      req0_valid = 1'b1; req0_index = 6'd1; req0_argument = 32'hAAAA_0000; req0_timeout_en = 1'b0;
      req1_valid = 1'b1; req1_index = 6'd2; req1_argument = 32'hBBBB_0000; req1_timeout_en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         exp_t e;
         r = {$urandom, $urandom, $urandom, $urandom, 8'(i)};
         e.id = 1'(i % 2);
         e.to = 1'b0;
         e.data = r;
         sb_q.push_back(e);
         model_rsp = r;
         wait_grant(1'(i % 2));
         check_eq("rr_index", cmd_index, (i % 2 == 1) ? 6'd2 : 6'd1);
         drive_phase(3, r, 1'b0, 1'(i % 2));
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      tick();

      // Reset 3 cycles into BUSY, then a pending req1 is granted normally.
      do_reset();
      model_rsp = 136'd0;
      begin
         exp_t e;
         e.id = 1'b1; e.to = 1'b0; e.data = 136'd0;
         sb_q.push_back(e);
      end
      req1_valid = 1'b1; req1_index = 6'd5; req1_argument = 32'h0000_5555; req1_timeout_en = 1'b1;
      wait_grant(1'b1);
      repeat (3) tick();
      check_eq("busy_before_rst", busy, 1'b1);
      #2 reset = 1'b1;
      #1;
      check_all_zero("async_rst");
      sb_q.delete();
      model_rsp = 136'd0;
      tick();
      reset = 1'b0;
      do_cmd(1'b1, 6'd5, 32'h0000_5555, 1'b1, 4, 136'h77_1234);
      tick();
      check_eq("sb_drained", sb_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
